// File: rtl/mouse_pkg.sv
// Shared types and default widths for the mouse-to-tile decoder.
// The conversion FSM state enum lives here so the bench can name states too.
package mouse_pkg;

  localparam int POS_W_DEF = 12;
  localparam int IDX_W_DEF = 5;

  typedef enum logic [1:0] {
    S_LATCH  = 2'd0,
    S_DIV    = 2'd1,
    S_UPDATE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/tile_axis_div.sv
// One axis of the tile converter: a subtractive divider that peels off one
// tile edge per step and reports when the remainder is exhausted or out of range.
module tile_axis_div
  import mouse_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [POS_W-1:0] offset,
  input  logic             step,
  input  logic [7:0]       field_size,
  input  logic [IDX_W-1:0] board_size,
  output logic             done,
  output logic             overflow,
  output logic [IDX_W-1:0] idx
);

  logic [POS_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [POS_W-1:0] fs_ext;

  assign fs_ext   = {{(POS_W-8){1'b0}}, field_size};
  assign done     = (rem_q < fs_ext);
  assign overflow = (idx_q == board_size);
  assign idx      = idx_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rem_d = rem_q;
    idx_d = idx_q;
    if (load) begin
      rem_d = offset;
      idx_d = '0;
    end else if (step && !done) begin
      rem_d = rem_q - fs_ext;
      idx_d = idx_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      idx_q <= '0;
    end else begin
      rem_q <= rem_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/mouse_tile_decoder.sv
// Maps the cursor to a board tile with a sequential divider and turns
// synchronised button edges into single-cycle dig/flag game events.
module mouse_tile_decoder
  import mouse_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] mouse_xpos,
  input  logic [POS_W-1:0] mouse_ypos,
  input  logic             left,
  input  logic             right,
  input  logic [POS_W-1:0] board_xpos,
  input  logic [POS_W-1:0] board_ypos,
  input  logic [7:0]       field_size,
  input  logic [IDX_W-1:0] board_size,
  input  logic             enable,
  output logic             hover_valid,
  output logic [IDX_W-1:0] hover_col,
  output logic [IDX_W-1:0] hover_row,
  output logic             dig,
  output logic             flag,
  output logic [IDX_W-1:0] evt_col,
  output logic [IDX_W-1:0] evt_row
);

  conv_state_e      state_q, state_d;
  logic [7:0]       fs_q, fs_d;
  logic [IDX_W-1:0] bs_q, bs_d;
  logic             outside_q, outside_d;
  logic             hover_valid_q, hover_valid_d;
  logic [IDX_W-1:0] hover_col_q, hover_col_d, hover_row_q, hover_row_d;

  logic             div_load, div_step;
  logic             col_done, row_done, col_ovf, row_ovf;
  logic [IDX_W-1:0] col_idx, row_idx;
  logic [POS_W-1:0] dx, dy;

  logic             left_s1_q, left_s2_q, left_prev_q;
  logic             right_s1_q, right_s2_q, right_prev_q;
  logic             left_press, left_release, right_press;

  logic             press_valid_q, press_valid_d;
  logic [IDX_W-1:0] press_col_q, press_col_d, press_row_q, press_row_d;
  logic             dig_q, dig_d, flag_q, flag_d;
  logic [IDX_W-1:0] evt_col_q, evt_col_d, evt_row_q, evt_row_d;

  assign dx = mouse_xpos - board_xpos;
  assign dy = mouse_ypos - board_ypos;

  tile_axis_div #(.POS_W(POS_W), .IDX_W(IDX_W)) u_col_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (div_load),
    .offset     (dx),
    .step       (div_step),
    .field_size (fs_q),
    .board_size (bs_q),
    .done       (col_done),
    .overflow   (col_ovf),
    .idx        (col_idx)
  );

  tile_axis_div #(.POS_W(POS_W), .IDX_W(IDX_W)) u_row_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (div_load),
    .offset     (dy),
    .step       (div_step),
    .field_size (fs_q),
    .board_size (bs_q),
    .done       (row_done),
    .overflow   (row_ovf),
    .idx        (row_idx)
  );

  always_comb begin
    state_d       = state_q;
    fs_d          = fs_q;
    bs_d          = bs_q;
    outside_d     = outside_q;
    hover_valid_d = hover_valid_q;
    hover_col_d   = hover_col_q;
    hover_row_d   = hover_row_q;
    div_load      = 1'b0;
    div_step      = 1'b0;
    unique case (state_q)
      S_LATCH: begin
        fs_d     = field_size;
        bs_d     = board_size;
        div_load = 1'b1;
        if (mouse_xpos < board_xpos || mouse_ypos < board_ypos ||
            field_size == 8'd0 || board_size == '0) begin
          outside_d = 1'b1;
          state_d   = S_UPDATE;
        end else begin
          outside_d = 1'b0;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        // Range check wins over completion: idx == board_size is off the board.
        if (col_ovf || row_ovf) begin
          outside_d = 1'b1;
          state_d   = S_UPDATE;
        end else if (col_done && row_done) begin
          state_d = S_UPDATE;
        end else begin
          div_step = 1'b1;
        end
      end
      S_UPDATE: begin
        hover_valid_d = !outside_q;
        if (!outside_q) begin
          hover_col_d = col_idx;
          hover_row_d = row_idx;
        end
        state_d = S_LATCH;
      end
      default: state_d = S_LATCH;
    endcase
  end

  assign left_press   =  left_s2_q  & ~left_prev_q;
  assign left_release = ~left_s2_q  &  left_prev_q;
  assign right_press  =  right_s2_q & ~right_prev_q;

  always_comb begin
    press_valid_d = press_valid_q;
    press_col_d   = press_col_q;
    press_row_d   = press_row_q;
    evt_col_d     = evt_col_q;
    evt_row_d     = evt_row_q;
    dig_d         = 1'b0;
    flag_d        = 1'b0;
    if (!enable) begin
      press_valid_d = 1'b0;
    end else begin
      if (left_press) begin
        press_valid_d = hover_valid_q;
        press_col_d   = hover_col_q;
        press_row_d   = hover_row_q;
      end else if (left_release) begin
        if (press_valid_q && hover_valid_q &&
            hover_col_q == press_col_q && hover_row_q == press_row_q) begin
          dig_d     = 1'b1;
          evt_col_d = hover_col_q;
          evt_row_d = hover_row_q;
        end
        press_valid_d = 1'b0;
      end
      // A dig in the same cycle suppresses the flag so the two never coincide.
      if (right_press && hover_valid_q && !dig_d) begin
        flag_d    = 1'b1;
        evt_col_d = hover_col_q;
        evt_row_d = hover_row_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_LATCH;
      fs_q          <= '0;
      bs_q          <= '0;
      outside_q     <= 1'b0;
      hover_valid_q <= 1'b0;
      hover_col_q   <= '0;
      hover_row_q   <= '0;
      left_s1_q     <= 1'b0;
      left_s2_q     <= 1'b0;
      left_prev_q   <= 1'b0;
      right_s1_q    <= 1'b0;
      right_s2_q    <= 1'b0;
      right_prev_q  <= 1'b0;
      press_valid_q <= 1'b0;
      press_col_q   <= '0;
      press_row_q   <= '0;
      dig_q         <= 1'b0;
      flag_q        <= 1'b0;
      evt_col_q     <= '0;
      evt_row_q     <= '0;
    end else begin
      state_q       <= state_d;
      fs_q          <= fs_d;
      bs_q          <= bs_d;
      outside_q     <= outside_d;
      hover_valid_q <= hover_valid_d;
      hover_col_q   <= hover_col_d;
      hover_row_q   <= hover_row_d;
      left_s1_q     <= left;
      left_s2_q     <= left_s1_q;
      left_prev_q   <= left_s2_q;
      right_s1_q    <= right;
      right_s2_q    <= right_s1_q;
      right_prev_q  <= right_s2_q;
      press_valid_q <= press_valid_d;
      press_col_q   <= press_col_d;
      press_row_q   <= press_row_d;
      dig_q         <= dig_d;
      flag_q        <= flag_d;
      evt_col_q     <= evt_col_d;
      evt_row_q     <= evt_row_d;
    end
  end

  assign hover_valid = hover_valid_q;
  assign hover_col   = hover_col_q;
  assign hover_row   = hover_row_q;
  assign dig         = dig_q;
  assign flag        = flag_q;
  assign evt_col     = evt_col_q;
  assign evt_row     = evt_row_q;

endmodule

// File: tb/tb_mouse_tile_decoder.sv
// Directed bench for mouse_tile_decoder: a division-based hover model checked
// every settled cycle, plus literal expectations for clicks, flags and reset.
module tb_mouse_tile_decoder;
  import mouse_pkg::*;

  localparam int POS_W   = 12;
  localparam int IDX_W   = 5;
  localparam int BX      = 100;
  localparam int BY      = 50;
  localparam int FS      = 32;
  localparam int BS      = 8;
  // One conversion already in flight plus a full fresh one, plus a margin cycle.
  localparam int LAG_MAX = 2 * (BS + 2) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [POS_W-1:0] mouse_xpos, mouse_ypos, board_xpos, board_ypos;
  logic             left, right, enable;
  logic [7:0]       field_size;
  logic [IDX_W-1:0] board_size;
  logic             hover_valid, dig, flag;
  logic [IDX_W-1:0] hover_col, hover_row, evt_col, evt_row;

  always #5 clk = ~clk;

  mouse_tile_decoder #(.POS_W(POS_W), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mouse_xpos  (mouse_xpos),
    .mouse_ypos  (mouse_ypos),
    .left        (left),
    .right       (right),
    .board_xpos  (board_xpos),
    .board_ypos  (board_ypos),
    .field_size  (field_size),
    .board_size  (board_size),
    .enable      (enable),
    .hover_valid (hover_valid),
    .hover_col   (hover_col),
    .hover_row   (hover_row),
    .dig         (dig),
    .flag        (flag),
    .evt_col     (evt_col),
    .evt_row     (evt_row)
  );

  int n_cmp = 0;
  int n_err = 0;
  int dig_cnt = 0;
  int flag_cnt = 0;
  int stable_cnt = 0;
  logic [2*POS_W-1:0] last_in = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tile under the cursor by plain integer division on the fixed board.
  function automatic void model_hover(input int x, input int y,
                                      output bit v, output int c, output int r);
    c = 0;
    r = 0;
    v = 1'b0;
    if (x >= BX && y >= BY) begin
      c = (x - BX) / FS;
      r = (y - BY) / FS;
      v = (c < BS) && (r < BS);
    end
  endfunction

  always @(negedge clk) begin
    bit mv;
    int mc, mr;
    if (!rst_n || {mouse_xpos, mouse_ypos} != last_in) stable_cnt = 0;
    else stable_cnt++;
    last_in = {mouse_xpos, mouse_ypos};
    if (rst_n) begin
      if (dig) dig_cnt++;
      if (flag) flag_cnt++;
      check("dig_flag_exclusive", {31'd0, dig & flag}, 32'd0);
      if (stable_cnt >= LAG_MAX) begin
        model_hover(int'(mouse_xpos), int'(mouse_ypos), mv, mc, mr);
        check("model_hover_valid", {31'd0, hover_valid}, {31'd0, mv});
        if (mv) begin
          check("model_hover_col", 32'(hover_col), mc);
          check("model_hover_row", 32'(hover_row), mr);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_cursor(input int x, input int y);
    mouse_xpos = POS_W'(x);
    mouse_ypos = POS_W'(y);
    tick(LAG_MAX + 2);
  endtask

  task automatic check_hover(input string name, input int v, input int c, input int r);
    check({name, "_valid"}, {31'd0, hover_valid}, v);
    if (v != 0) begin
      check({name, "_col"}, 32'(hover_col), c);
      check({name, "_row"}, 32'(hover_row), r);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_hover_valid"}, {31'd0, hover_valid}, 0);
    check({name, "_hover_col"},   32'(hover_col), 0);
    check({name, "_hover_row"},   32'(hover_row), 0);
    check({name, "_dig"},         {31'd0, dig}, 0);
    check({name, "_flag"},        {31'd0, flag}, 0);
    check({name, "_evt_col"},     32'(evt_col), 0);
    check({name, "_evt_row"},     32'(evt_row), 0);
  endtask

  initial begin
    int  d0, f0, found;
    bit  mv;
    int  mc, mr;

    rst_n      = 1'b0;
    mouse_xpos = '0;
    mouse_ypos = '0;
    left       = 1'b0;
    right      = 1'b0;
    board_xpos = POS_W'(BX);
    board_ypos = POS_W'(BY);
    field_size = 8'(FS);
    board_size = IDX_W'(BS);
    enable     = 1'b1;

    // Pin the model to hand-computed tiles.
    model_hover(165, 90, mv, mc, mr);
    check("pin_165_90", {mv, 8'(mc), 8'(mr)}, {1'b1, 8'd2, 8'd1});
    model_hover(356, 90, mv, mc, mr);
    check("pin_356_90_valid", {31'd0, mv}, 0);
    model_hover(300, 300, mv, mc, mr);
    check("pin_300_300", {mv, 8'(mc), 8'(mr)}, {1'b1, 8'd6, 8'd7});

    tick(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Basic mapping and boundaries.
    set_cursor(165, 90);
    check_hover("t1", 1, 2, 1);
    set_cursor(99, 90);
    check_hover("t2_left_of_board", 0, 0, 0);
    set_cursor(356, 90);
    check_hover("t2_col8", 0, 0, 0);
    set_cursor(355, 90);
    check_hover("t2_col7", 1, 7, 1);

    // Click on one tile: release-to-dig latency of three edges.
    set_cursor(165, 90);
    d0 = dig_cnt;
    left = 1'b1;
    tick(6);
    left = 1'b0;
    tick(2);
    check("t3_dig_early", {31'd0, dig}, 0);
    tick(1);
    check("t3_dig_pulse", {31'd0, dig}, 1);
    check("t3_evt_col", 32'(evt_col), 2);
    check("t3_evt_row", 32'(evt_row), 1);
    tick(1);
    check("t3_dig_single", {31'd0, dig}, 0);
    tick(3);
    check("t3_dig_count", dig_cnt - d0, 1);

    // Drag to another tile before release: no dig, evt held.
    d0 = dig_cnt;
    left = 1'b1;
    tick(6);
    set_cursor(200, 90);
    left = 1'b0;
    tick(6);
    check("t3_drag_no_dig", dig_cnt - d0, 0);
    check("t3_drag_evt_col", 32'(evt_col), 2);

    // Enable dropped between press and release cancels the click.
    set_cursor(165, 90);
    d0 = dig_cnt;
    left = 1'b1;
    tick(6);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    left = 1'b0;
    tick(6);
    check("t3_enable_cancel", dig_cnt - d0, 0);

    // Right press flags.
    set_cursor(300, 300);
    f0 = flag_cnt;
    right = 1'b1;
    tick(6);
    right = 1'b0;
    tick(4);
    check("t4_flag_count", flag_cnt - f0, 1);
    check("t4_evt_col", 32'(evt_col), 6);
    check("t4_evt_row", 32'(evt_row), 7);

    set_cursor(50, 50);
    f0 = flag_cnt;
    right = 1'b1;
    tick(6);
    right = 1'b0;
    tick(4);
    check("t4_off_board_no_flag", flag_cnt - f0, 0);
    check("t4_off_board_evt_col", 32'(evt_col), 6);

    set_cursor(300, 300);
    enable = 1'b0;
    f0 = flag_cnt;
    right = 1'b1;
    tick(6);
    right = 1'b0;
    tick(4);
    enable = 1'b1;
    check("t4_disabled_no_flag", flag_cnt - f0, 0);

    // Left release and right press land in the same synchronised cycle.
    set_cursor(165, 90);
    d0 = dig_cnt;
    f0 = flag_cnt;
    left = 1'b1;
    tick(6);
    left = 1'b0;
    right = 1'b1;
    tick(6);
    right = 1'b0;
    tick(4);
    check("t5_dig_count", dig_cnt - d0, 1);
    check("t5_flag_count", flag_cnt - f0, 0);
    check("t5_evt_col", 32'(evt_col), 2);
    check("t5_evt_row", 32'(evt_row), 1);

    // Reset in the middle of a division.
    set_cursor(355, 300);
    check_hover("t6_pre", 1, 7, 7);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (dut.state_q == S_DIV) found = 1;
    end
    check("t6_div_reached", found, 1);
    tick(3);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_mid_reset");
    tick(2);
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      tick(1);
      if (hover_valid === 1'b1) found = 1;
    end
    check("t6_recover_in_12", found, 1);
    check_hover("t6_post", 1, 7, 7);
    tick(LAG_MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
